gpu_pixel_writer: RTL

GPU_PIXEL_WRITER -- requirements
Module: gpu_pixel_writer

---
 rtl/gpu_pkg.sv | 22 ++
 rtl/gpu_pixel_fifo.sv | 48 ++++
 rtl/gpu_pixel_writer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: framebuffer geometry defaults, pixel-writer FSM state
// and small arithmetic helpers used by the raster back-end.
package gpu_pkg;

  localparam int GPU_WIDTH       = 640;
  localparam int GPU_HEIGHT      = 480;
  localparam int GPU_WIDTH_BITS  = 10;
  localparam int GPU_HEIGHT_BITS = 9;
  localparam int GPU_ADDR_BITS   = 19;
  localparam int GPU_COLOR_BITS  = 24;
  localparam int GPU_FIFO_DEPTH  = 4;

  typedef enum logic [0:0] {
    WR_IDLE  = 1'b0,
    WR_ISSUE = 1'b1
  } writer_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Synchronous FIFO for pending framebuffer writes; pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module gpu_pixel_fifo #(
  parameter  int DATA_BITS = 43,
  parameter  int DEPTH     = 4,
  localparam int PTR_BITS  = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] pop_data,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_BITS:0]    count
);

  logic [DATA_BITS-1:0] mem_r [DEPTH];
  logic [PTR_BITS:0]    wr_ptr_r;
  logic [PTR_BITS:0]    rd_ptr_r;
  logic                 do_push_s;
  logic                 do_pop_s;

  assign count     = wr_ptr_r - rd_ptr_r;
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (count == (PTR_BITS + 1)'(DEPTH));
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign pop_data  = mem_r[rd_ptr_r[PTR_BITS-1:0]];

  // Read/write pointer registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (PTR_BITS + 1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (PTR_BITS + 1)'(1);
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[PTR_BITS-1:0]] <= push_data;
  end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Pixel writer: clips incoming pixels, buffers in-range ones as framebuffer word
// writes, issues them in order and reports flush completion.
module gpu_pixel_writer
  import gpu_pkg::*;
#(
  parameter int WIDTH       = GPU_WIDTH,
  parameter int HEIGHT      = GPU_HEIGHT,
  parameter int WIDTH_BITS  = GPU_WIDTH_BITS,
  parameter int HEIGHT_BITS = GPU_HEIGHT_BITS,
  parameter int ADDR_BITS   = GPU_ADDR_BITS,
  parameter int COLOR_BITS  = GPU_COLOR_BITS,
  parameter int FIFO_DEPTH  = GPU_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   pix_valid,
  input  logic [WIDTH_BITS-1:0]  pix_x,
  input  logic [HEIGHT_BITS-1:0] pix_y,
  input  logic [COLOR_BITS-1:0]  pix_color,
  output logic                   pix_ready,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   mem_req,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [COLOR_BITS-1:0]  mem_wdata,
  input  logic                   mem_ack,
  output logic                   idle,
  output logic [7:0]             drop_count
);

  localparam int ENTRY_BITS = ADDR_BITS + COLOR_BITS;
  localparam int CNT_BITS   = $clog2(FIFO_DEPTH) + 1;

  writer_state_e         state_r;
  writer_state_e         state_next_s;
  logic                  ready_en_r;
  logic                  flush_pending_r;
  logic [7:0]            drop_count_r;
  logic                  full_s;
  logic                  empty_s;
  logic [CNT_BITS-1:0]   count_s;
  logic [ENTRY_BITS-1:0] head_s;
  logic [ENTRY_BITS-1:0] entry_s;
  logic [ADDR_BITS-1:0]  addr_s;
  logic                  in_range_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  drop_s;
  logic                  issue_s;
  logic                  pop_s;
  logic                  last_pop_s;
  logic                  idle_s;
  logic                  flush_done_s;

  assign in_range_s = (32'(pix_x) < 32'(WIDTH)) && (32'(pix_y) < 32'(HEIGHT));
  assign addr_s     = ADDR_BITS'(pix_y) * ADDR_BITS'(WIDTH) + ADDR_BITS'(pix_x);
  assign entry_s    = {addr_s, pix_color};

  // No pass-through: a pop in the same cycle does not reopen a full buffer.
  assign pix_ready  = ready_en_r & ~full_s;
  assign accept_s   = pix_valid & pix_ready;
  assign push_s     = accept_s & in_range_s;
  assign drop_s     = accept_s & ~in_range_s;

  assign issue_s    = (state_r == WR_ISSUE);
  assign pop_s      = issue_s & mem_ack;
  assign last_pop_s = pop_s & (count_s == CNT_BITS'(1));
  assign idle_s     = ~issue_s & empty_s;
  assign flush_done_s = flush_pending_r & idle_s;

  gpu_pixel_fifo #(
    .DATA_BITS (ENTRY_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push_s),
    .push_data (entry_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Next-state logic; entering ISSUE on the push itself gives a one-cycle request latency.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      WR_IDLE: begin
        if (push_s | ~empty_s) state_next_s = WR_ISSUE;
        else                   state_next_s = WR_IDLE;
      end
      WR_ISSUE: begin
        if (last_pop_s & ~push_s) state_next_s = WR_IDLE;
        else                      state_next_s = WR_ISSUE;
      end
      default: state_next_s = WR_IDLE;
    endcase
  end

  // State, ready enable, flush tracking and clip counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r         <= WR_IDLE;
      ready_en_r      <= 1'b0;
      flush_pending_r <= 1'b0;
      drop_count_r    <= 8'd0;
    end else begin
      state_r    <= state_next_s;
      ready_en_r <= 1'b1;
      if (flush_done_s) flush_pending_r <= 1'b0;
      else if (flush)   flush_pending_r <= 1'b1;
      if (drop_s) drop_count_r <= sat_inc8(drop_count_r);
    end
  end

  assign mem_req    = issue_s;
  assign mem_addr   = issue_s ? head_s[ENTRY_BITS-1:COLOR_BITS] : {ADDR_BITS{1'b0}};
  assign mem_wdata  = issue_s ? head_s[COLOR_BITS-1:0] : {COLOR_BITS{1'b0}};
  assign idle       = idle_s;
  assign flush_done = flush_done_s;
  assign drop_count = drop_count_r;

endmodule
